// File: rtl/lamp_pkg.sv
// lamp_pkg: shared defaults, width helper and switch index type for the lamp switch conditioner
package lamp_pkg;

    localparam int N_SW_DEF = 3;
    localparam int DEB_CYCLES_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [clog2(N_SW_DEF)-1:0] sw_idx_t;

endpackage

// File: rtl/lamp_switch_conditioner_if.sv
// lamp_switch_conditioner_if: raw switch pins in, clean switch vector and lamp/change status out
interface lamp_switch_conditioner_if
    import lamp_pkg::*;
#(
    parameter int N_SW = N_SW_DEF
);

    localparam int IDX_W = clog2(N_SW);

    logic [N_SW-1:0]  sw_raw;
    logic [N_SW-1:0]  sw_stable;
    logic             lamp;
    logic             chg;
    logic [IDX_W-1:0] chg_idx;
    logic             chg_multi;

    modport master (
        input  sw_raw,
        output sw_stable,
        output lamp,
        output chg,
        output chg_idx,
        output chg_multi
    );

    modport slave (
        output sw_raw,
        input  sw_stable,
        input  lamp,
        input  chg,
        input  chg_idx,
        input  chg_multi
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchronizer plus saturating mismatch counter for one switch
module sw_debounce_bit
    import lamp_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic flip
);

    localparam int CW = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch = s2 ^ stable;
    assign flip = mismatch && (cnt == CNT_MAX);

    // Any match, or an accepted flip, restarts the count so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            cnt    <= (!mismatch || flip) ? '0 : cnt + CW'(1);
            stable <= stable ^ flip;
        end
    end

endmodule

// File: rtl/lamp_switch_conditioner.sv
// lamp_switch_conditioner: debounced switch vector, parity lamp and priority-encoded change strobe
module lamp_switch_conditioner
    import lamp_pkg::*;
#(
    parameter int N_SW = N_SW_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    lamp_switch_conditioner_if.master bus
);

    localparam int IDX_W = clog2(N_SW);

    logic [N_SW-1:0]  stable;
    logic [N_SW-1:0]  flip;
    logic [N_SW-1:0]  stable_n;
    logic [IDX_W-1:0] idx_n;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.sw_raw[g]),
            .stable(stable[g]),
            .flip  (flip[g])
        );
    end

    assign bus.sw_stable = stable;
    // Parity is taken from the next stable value so lamp lands on the same edge.
    assign stable_n = stable ^ flip;

    always_comb begin
        idx_n = '0;
        for (int i = N_SW - 1; i >= 0; i--)
            idx_n = flip[i] ? IDX_W'(i) : idx_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.lamp      <= 1'b0;
            bus.chg       <= 1'b0;
            bus.chg_idx   <= '0;
            bus.chg_multi <= 1'b0;
        end else begin
            bus.lamp      <= ^stable_n;
            bus.chg       <= |flip;
            bus.chg_idx   <= idx_n;
            bus.chg_multi <= $countones(flip) > 1;
        end
    end

endmodule

// File: tb/tb_lamp_switch_conditioner.sv
// tb_lamp_switch_conditioner: directed and random stimulus checked against a sliding-window debounce model
module tb_lamp_switch_conditioner;

    localparam int N = 3;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    lamp_switch_conditioner_if #(.N_SW(N)) bus ();

    lamp_switch_conditioner #(
        .N_SW(N),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [N-1:0] m_stable;
    logic         m_lamp;
    logic         m_chg;
    logic [1:0]   m_idx;
    logic         m_multi;
    logic [N-1:0] sync_q[$];
    logic [N-1:0] win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sync_q = '{3'b000, 3'b000};
        win.delete();
        m_stable = '0;
        m_lamp = 1'b0;
        m_chg = 1'b0;
        m_idx = '0;
        m_multi = 1'b0;
    endtask

    // A bit flips once its last DEB synchronized samples all disagree with the stable level.
    task automatic model_step();
        logic [N-1:0] s2v;
        logic [N-1:0] fl;
        s2v = sync_q.pop_front();
        sync_q.push_back(bus.sw_raw);
        win.push_back(s2v);
        if (win.size() > DEB) void'(win.pop_front());
        fl = '0;
        if (win.size() == DEB)
            for (int i = 0; i < N; i++) begin
                fl[i] = 1'b1;
                foreach (win[j]) if (win[j][i] == m_stable[i]) fl[i] = 1'b0;
            end
        m_stable = m_stable ^ fl;
        m_lamp = ^m_stable;
        m_chg = |fl;
        m_multi = $countones(fl) > 1;
        m_idx = '0;
        for (int i = N - 1; i >= 0; i--) if (fl[i]) m_idx = 2'(i);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sw_stable"}, 32'(bus.sw_stable), 32'(m_stable));
        chk({tag, ".lamp"}, 32'(bus.lamp), 32'(m_lamp));
        chk({tag, ".chg"}, 32'(bus.chg), 32'(m_chg));
        chk({tag, ".chg_idx"}, 32'(bus.chg_idx), 32'(m_idx));
        chk({tag, ".chg_multi"}, 32'(bus.chg_multi), 32'(m_multi));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    task automatic hold(input logic [N-1:0] v, input int n, input string tag, output int first, output int pulses);
        bus.sw_raw = v;
        first = 0;
        pulses = 0;
        for (int t = 1; t <= n; t++) begin
            tick(tag);
            if (bus.chg) begin
                pulses++;
                if (first == 0) first = t;
            end
        end
    endtask

    logic [N-1:0] gray[8];
    int           exp_idx[7];
    int           idx_log[$];
    int           first;
    int           pulses;
    int           total;
    logic         saw_multi;

    initial begin
        gray = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        exp_idx = '{0, 1, 0, 2, 0, 1, 0};
        rst = 1'b1;
        bus.sw_raw = '0;
        model_reset();
        #1;
        check_all("reset");
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b0;

        hold(3'b000, 20, "idle", first, pulses);
        chk("idle_pulses", 32'(pulses), 0);

        hold(3'b001, 10, "s1_rise", first, pulses);
        chk("s1_latency", 32'(first), 6);
        chk("s1_pulses", 32'(pulses), 1);
        chk("s1_stable", 32'(bus.sw_stable), 32'h1);
        chk("s1_lamp", 32'(bus.lamp), 1);

        hold(3'b000, 10, "s1_fall", first, pulses);
        total = 0;
        for (int b = 0; b < 6; b++) begin
            hold((b % 2 == 0) ? 3'b010 : 3'b000, 2, "bounce", first, pulses);
            total += pulses;
        end
        chk("bounce_pulses", 32'(total), 0);
        hold(3'b010, 10, "s2_settle", first, pulses);
        chk("s2_latency", 32'(first), 6);
        chk("s2_pulses", 32'(pulses), 1);
        chk("s2_stable", 32'(bus.sw_stable), 32'h2);
        chk("s2_lamp", 32'(bus.lamp), 1);

        hold(3'b000, 10, "s2_fall", first, pulses);
        bus.sw_raw = 3'b101;
        saw_multi = 1'b0;
        pulses = 0;
        for (int t = 0; t < 10; t++) begin
            tick("dual");
            if (bus.chg) begin
                pulses++;
                saw_multi = bus.chg_multi;
                chk("dual_idx", 32'(bus.chg_idx), 0);
            end
        end
        chk("dual_pulses", 32'(pulses), 1);
        chk("dual_multi", 32'(saw_multi), 1);
        chk("dual_stable", 32'(bus.sw_stable), 32'h5);
        chk("dual_lamp", 32'(bus.lamp), 0);

        hold(3'b000, 10, "dual_fall", first, pulses);
        for (int k = 1; k < 8; k++) begin
            bus.sw_raw = gray[k];
            for (int t = 0; t < 10; t++) begin
                tick("gray");
                if (bus.chg) idx_log.push_back(int'(bus.chg_idx));
            end
            chk("gray_lamp", 32'(bus.lamp), 32'(^gray[k]));
        end
        chk("gray_pulses", 32'(idx_log.size()), 7);
        foreach (idx_log[i]) if (i < 7) chk("gray_idx", 32'(idx_log[i]), 32'(exp_idx[i]));

        reset_pulse("rst_live");
        hold(3'b000, 10, "post_rst", first, pulses);
        hold(3'b010, 4, "mid_count", first, pulses);
        chk("mid_count_pulses", 32'(pulses), 0);
        reset_pulse("rst_mid");
        hold(3'b010, 10, "after_rst", first, pulses);
        chk("rst_latency", 32'(first), 6);
        chk("rst_pulses", 32'(pulses), 1);
        chk("rst_stable", 32'(bus.sw_stable), 32'h2);

        for (int s = 0; s < 60; s++)
            hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 8)), "random", first, pulses);
        hold(3'($urandom_range(0, 7)), 10, "random_settle", first, pulses);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lamp_switch_conditioner.md
Name: lamp_switch_conditioner

Overview:
- Producer side of the three-way lamp switch interface: the block that turns raw, bouncing, asynchronous wall-switch inputs into the clean S[3:1] vector the lamp decoder logic consumes.
- Per switch: two-flop synchronizer plus debounce counter.
- Also drives a registered lamp output (odd parity of the stable switches), a one-cycle change strobe, and a priority-encoded index of the switch that changed.
- Sits between the board switch pins and the lamp decoder/LED.

Parameters:
- N_SW, 3, number of switches.
- DEB_CYCLES, 4, consecutive mismatched sync cycles required to accept a new level (>=2). Simulation default; the board build overrides it.
- IDX_W, 2, width of chg_idx, derived as clog2(N_SW). Localparam, not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw_raw  in  N_SW  raw switch levels, asynchronous to clk; bit 0 = S1.
- sw_stable  out  N_SW  debounced switch vector (S[N_SW:1]).
- lamp  out  1  XOR of sw_stable, registered.
- chg  out  1  one-cycle pulse when any sw_stable bit flips.
- chg_idx  out  IDX_W  lowest index among bits that flipped this cycle.
- chg_multi  out  1  high with chg when more than one bit flipped in the same cycle.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-high (rst).
  - While rst=1: sync flops, counters, sw_stable, lamp, chg, chg_idx and chg_multi are all 0, immediately (not clock-gated).
  - Reset mid-debounce discards the count; no pulse is emitted on release.
- Synchronizer
  - sw_raw[i] -> s1[i] -> s2[i], 2 flops, no logic between them.
- Debounce, per bit
  - mismatch = s2[i] != sw_stable[i].
  - If mismatch=0: cnt[i] <= 0.
  - If mismatch=1 and cnt[i] < DEB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If mismatch=1 and cnt[i] == DEB_CYCLES-1: sw_stable[i] <= s2[i], cnt[i] <= 0, flip[i]=1.
  - Counter width is clog2(DEB_CYCLES); the counter never wraps.
- Latency
  - Raw level settles before edge E0 and is held. sw_stable updates at edge E0+1+DEB_CYCLES (edge 5 for default).
  - Any bounce that returns s2 to the stable value clears the count. Glitches shorter than DEB_CYCLES sync cycles never propagate.
- Outputs
  - Registered at the same edge as the sw_stable update. lamp <= ^(next sw_stable), so lamp is never a cycle behind sw_stable.
  - chg <= |flip. chg_idx <= lowest i with flip[i], else 0. chg_multi <= popcount(flip) > 1.
  - chg is high for exactly one cycle per update edge, even if another bit flips on the next edge (back-to-back pulses allowed).
- Power-up with switches high
  - Switches already high at reset release debounce normally: they produce a chg pulse and lamp update after 1+DEB_CYCLES edges.
- No handshake
  - Consumers sample sw_stable/lamp level-wise or on chg.

Decomposition:
- Package lamp_pkg
  - Default N_SW and DEB_CYCLES.
  - clog2 function.
  - Switch index typedef (IDX_W bits).
- Sub-module sw_debounce_bit
  - One synchronizer, counter, and stable flop.
  - Outputs stable and flip.
  - Instantiated N_SW times by generate.
- Top level owns the priority encoder, parity, and output registers.

Test Plan:
- Reset with sw_raw=000, hold 20 cycles -> all outputs 0, chg never asserted.
- sw_raw 000->001 before edge E0, held -> at E0+5: sw_stable=001, lamp=1, chg=1 for exactly 1 cycle, chg_idx=0, chg_multi=0.
- S2 bounces 0/1 every 2 cycles for 12 cycles, then held 1 -> no chg during bounce; single chg with chg_idx=1 five edges after the final bounce edge; sw_stable=010, lamp=1.
- From 000, S1 and S3 rise on the same edge -> sw_stable=101, lamp=0, one chg, chg_idx=0, chg_multi=1.
- Gray walk 000,001,011,010,110,111,101,100, 10 cycles each -> after each update lamp equals XOR of the code; exactly 7 chg pulses; chg_idx = 0,1,0,2,0,1,0 in order.
- sw_raw=010 with rst asserted mid-count (cnt=2) -> outputs 0 within the same cycle. After release at edge R0: sw_stable=010, lamp=1, chg=1 at edge R0+5.
